ts_sync_aligner: RTL and testbench

- Upstream front-end of the TS processing RAM/filter block (tsp_ram).
- Takes a raw, unaligned MPEG-TS byte stream on mpeg_clk and finds the 188-byte packet grid from 0x47 sync bytes.
- Drives the mpeg_data/mpeg_valid/mpeg_sync interface that the filter/replacer stage consumes.
- Only whole, correctly synced packets are forwarded; packets with a corrupt sync byte are dropped.

---
 rtl/ts_sync_aligner.sv | 178 +++++++++++++++++
 tb/tb_ts_sync_aligner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ts_sync_aligner.sv
// MPEG-TS sync aligner: finds the 188-byte packet grid from 0x47 sync bytes and forwards
// whole synced packets. Define TS_ERR_CNT_EN to enable the drop/loss counters.
module ts_sync_aligner #(
   parameter int unsigned PACK_BYTE_SIZE = 188,
   parameter logic [7:0]  SYNC_BYTE      = 8'h47,
   parameter int unsigned LOCK_THRESHOLD = 3,
   parameter int unsigned LOSS_THRESHOLD = 3
) (
   input  logic        mpeg_clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic [7:0]  mpeg_data,
   output logic        mpeg_valid,
   output logic        mpeg_sync,
   output logic        locked,
   output logic        pkt_drop,
   output logic [31:0] drop_count,
   output logic [15:0] loss_count
);

   localparam int unsigned  PosW    = $clog2(PACK_BYTE_SIZE);
   localparam logic [PosW-1:0] PosLast = PosW'(PACK_BYTE_SIZE - 1);
   localparam logic [3:0]   LockThr = 4'(LOCK_THRESHOLD);
   localparam logic [3:0]   LossThr = 4'(LOSS_THRESHOLD);

   typedef enum logic [1:0] {StHunt, StVerify, StLock} state_e;

   state_e          state_q, state_d;
   logic [PosW-1:0] pos_q, pos_d, pos_inc;
   logic [3:0]      hit_q, hit_d, hit_inc;
   logic [3:0]      miss_q, miss_d, miss_inc;
   logic            pass_q, pass_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            sync_q, sync_d;
   logic            drop_q, drop_d;
   logic            is_sync;

   assign is_sync  = (in_data == SYNC_BYTE);
   assign pos_inc  = (pos_q == PosLast) ? '0 : pos_q + PosW'(1);
   assign hit_inc  = hit_q + 4'd1;
   assign miss_inc = miss_q + 4'd1;

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      pass_d  = pass_q;
      data_d  = data_q;
      valid_d = 1'b0;
      sync_d  = 1'b0;
      drop_d  = 1'b0;
      if (in_valid) begin
         case (state_q)
            StHunt: begin
               if (is_sync) begin
                  pos_d = PosW'(1);
                  hit_d = 4'd1;
                  if (LOCK_THRESHOLD == 1) begin
                     state_d = StLock;
                     miss_d  = '0;
                     pass_d  = 1'b1;
                     valid_d = 1'b1;
                     sync_d  = 1'b1;
                     data_d  = in_data;
                  end else begin
                     state_d = StVerify;
                  end
               end
            end
            StVerify: begin
               pos_d = pos_inc;
               if (pos_q == '0) begin
                  if (is_sync) begin
                     hit_d = hit_inc;
                     if (hit_inc == LockThr) begin
                        state_d = StLock;
                        miss_d  = '0;
                        pass_d  = 1'b1;
                        valid_d = 1'b1;
                        sync_d  = 1'b1;
                        data_d  = in_data;
                     end
                  end else begin
                     // False sync candidate: drop back without rescanning this byte
                     state_d = StHunt;
                     hit_d   = '0;
                     pos_d   = '0;
                  end
               end
            end
            StLock: begin
               pos_d = pos_inc;
               if (pos_q == '0) begin
                  if (is_sync) begin
                     miss_d  = '0;
                     pass_d  = 1'b1;
                     valid_d = 1'b1;
                     sync_d  = 1'b1;
                     data_d  = in_data;
                  end else begin
                     miss_d = miss_inc;
                     pass_d = 1'b0;
                     drop_d = 1'b1;
                     if (miss_inc == LossThr) begin
                        state_d = StHunt;
                        hit_d   = '0;
                        pos_d   = '0;
                     end
                  end
               end else if (pass_q) begin
                  valid_d = 1'b1;
                  data_d  = in_data;
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge mpeg_clk) begin
      if (!rst_n) begin
         state_q <= StHunt;
         pos_q   <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         pass_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sync_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         pass_q  <= pass_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sync_q  <= sync_d;
         drop_q  <= drop_d;
      end
   end

   assign mpeg_data  = data_q;
   assign mpeg_valid = valid_q;
   assign mpeg_sync  = sync_q;
   assign pkt_drop   = drop_q;
   assign locked     = (state_q == StLock);

`ifdef TS_ERR_CNT_EN
   logic [31:0] drop_cnt_q;
   logic [15:0] loss_cnt_q;
   logic        lost;

   assign lost = (state_q == StLock) && (state_d == StHunt);

   // Saturating counters, cleared only by reset
   always_ff @(posedge mpeg_clk) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
         loss_cnt_q <= '0;
      end else begin
         if (drop_d && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
         if (lost && (loss_cnt_q != '1))   loss_cnt_q <= loss_cnt_q + 16'd1;
      end
   end

   assign drop_count = drop_cnt_q;
   assign loss_count = loss_cnt_q;
`else
   assign drop_count = '0;
   assign loss_count = '0;
`endif

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed self-checking bench for ts_sync_aligner: lock acquisition, drops, loss of lock,
// false sync rejection and mid-packet reset.
module tb_ts_sync_aligner;

   logic        mpeg_clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic [7:0]  mpeg_data;
   logic        mpeg_valid;
   logic        mpeg_sync;
   logic        locked;
   logic        pkt_drop;
   logic [31:0] drop_count;
   logic [15:0] loss_count;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_syncs  = 0;
   logic [7:0] exp_hold = 8'h00;

`ifdef TS_ERR_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   always #5 mpeg_clk = ~mpeg_clk;

   ts_sync_aligner dut (
      .mpeg_clk   (mpeg_clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .mpeg_data  (mpeg_data),
      .mpeg_valid (mpeg_valid),
      .mpeg_sync  (mpeg_sync),
      .locked     (locked),
      .pkt_drop   (pkt_drop),
      .drop_count (drop_count),
      .loss_count (loss_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pkt_byte(input int p, input int k);
      case (k)
         0:       return 8'h47;
         1:       return 8'h15;
         2:       return 8'h7f;
         3:       return 8'h10 | 8'(p & 15);
         default: return 8'((p * 3 + k) % 64);
      endcase
   endfunction

   // Called at a negedge; byte is captured on the next posedge, outputs checked at the next negedge
   task automatic send_byte(input logic [7:0] d, input bit fwd, input bit sy, input bit drp,
                            input int gap);
      in_data  = d;
      in_valid = 1'b1;
      @(negedge mpeg_clk);
      in_valid = 1'b0;
      if (fwd) exp_hold = d;
      check("valid", 32'(mpeg_valid), 32'(fwd));
      check("sync", 32'(mpeg_sync), 32'(fwd && sy));
      check("drop", 32'(pkt_drop), 32'(drp));
      check("data", 32'(mpeg_data), 32'(exp_hold));
      if (mpeg_sync) n_syncs++;
      for (int i = 0; i < gap; i++) begin
         @(negedge mpeg_clk);
         check("idle_valid", 32'(mpeg_valid), 32'd0);
         check("idle_drop", 32'(pkt_drop), 32'd0);
         check("idle_data", 32'(mpeg_data), 32'(exp_hold));
      end
   endtask

   task automatic send_packet(input int p, input int first, input int last, input logic [7:0] b0,
                              input bit fwd, input bit drp0, input bit exp_lock, input int gap,
                              input bit fake10);
      logic [7:0] d;
      for (int k = first; k <= last; k++) begin
         d = (k == 0) ? b0 : pkt_byte(p, k);
         if (fake10 && k == 10) d = 8'h47;
         send_byte(d, fwd, k == 0, drp0 && (k == 0), gap);
         if (k == 0) check("locked", 32'(locked), 32'(exp_lock));
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge mpeg_clk);
      rst_n    = 1'b1;
      exp_hold = 8'h00;
      check("rst_valid", 32'(mpeg_valid), 32'd0);
      check("rst_sync", 32'(mpeg_sync), 32'd0);
      check("rst_data", 32'(mpeg_data), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_drop", 32'(pkt_drop), 32'd0);
      check("rst_drop_count", drop_count, 32'd0);
      check("rst_loss_count", 32'(loss_count), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge mpeg_clk);
      do_reset();

      // Acquisition: 50 idle bytes then 5 packets, one valid byte every 4th cycle
      n_syncs = 0;
      for (int i = 0; i < 50; i++) send_byte(8'h00, 1'b0, 1'b0, 1'b0, 3);
      send_packet(1, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      send_packet(2, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      send_packet(3, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 3, 1'b0);
      send_packet(4, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 3, 1'b0);
      send_packet(5, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 3, 1'b0);
      check("sync_pulses", 32'(n_syncs), 32'd3);

      // Single corrupt sync byte while locked
      send_packet(6, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      send_packet(7, 0, 187, 8'h46, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      send_packet(8, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      check("drop_count_1", drop_count, CntEn ? 32'd1 : 32'd0);
      check("loss_count_0", 32'(loss_count), 32'd0);

      // Three misses lose lock, three good packets relock
      send_packet(9, 0, 187, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      send_packet(10, 0, 187, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      send_packet(11, 0, 187, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      check("drop_count_4", drop_count, CntEn ? 32'd4 : 32'd0);
      check("loss_count_1", 32'(loss_count), CntEn ? 32'd1 : 32'd0);
      send_packet(12, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(13, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(14, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 0, 1'b0);

      // False sync at payload offset 10, entered from HUNT mid-packet
      do_reset();
      send_packet(20, 5, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      send_packet(21, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(22, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(23, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(24, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      send_packet(25, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 0, 1'b0);

      // Reset mid-packet while locked, then relock
      send_packet(26, 0, 99, 8'h47, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      do_reset();
      send_packet(26, 100, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(27, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(28, 0, 187, 8'h47, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_packet(29, 0, 187, 8'h47, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      check("final_drop_count", drop_count, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
